ula_seq_param: RTL and testbench

Parametrised, clocked successor of the board-level combinational ULA. It registers operands on a start handshake and executes add, sub, AND, OR, XOR in one cycle. Multiply (shift-add) and divide (restoring) run iteratively over WIDTH cycles. It sits between the switch/key input logic and the BCD/7-segment display path, and it supplies registered zero, carry, negative and error flags to the LEDs.

---
 rtl/ula_pkg.sv | 22 ++
 rtl/ula_iter_muldiv.sv | 65 ++++++
 rtl/ula_seq_param.sv | 170 +++++++++++++++++
 tb/tb_ula_seq_param.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared opcodes, FSM encoding and width helper for the sequential ULA.
package ula_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, FIN} state_t;

  function automatic int res_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/ula_iter_muldiv.sv
// Shared shift-add multiply / restoring divide datapath; one partial step per step pulse.
module ula_iter_muldiv
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             mode,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo
);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [WIDTH:0]   sum, shl, diff;

  // acc_hi/acc_lo present the post-step value so the caller can capture the
  // final result on the same edge as the last step.
  always_comb begin
    sum  = {1'b0, hi_q} + {1'b0, m_q};
    shl  = {hi_q, lo_q[WIDTH-1]};
    diff = shl - {1'b0, m_q};
    if (mode == MODE_MUL) begin
      if (lo_q[0]) {acc_hi, acc_lo} = {sum, lo_q[WIDTH-1:1]};
      else         {acc_hi, acc_lo} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_hi = diff[WIDTH-1:0];
      acc_lo = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_hi = shl[WIDTH-1:0];
      acc_lo = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    m_d  = m_q;
    if (load) begin
      hi_d = '0;
      lo_d = opa;
      m_d  = opb;
    end else if (step) begin
      hi_d = acc_hi;
      lo_d = acc_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q  <= m_d;
    end
  end

endmodule

// File: rtl/ula_seq_param.sv
// Clocked ULA: single-cycle logic/arith ops, iterative mult/div, registered result and flags.
module ula_seq_param
  import ula_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int RES_W = res_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_neg,
  output logic             flag_error
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             cin_q, cin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             zero_q, zero_d, carry_q, carry_d, neg_q, neg_d, err_q, err_d;
  logic             done_q, done_d, busy_q, busy_d;
  logic             is_iter, it_load, it_step;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH:0]   sum, diff;

  // Division by zero short-circuits to the single-cycle error path.
  assign is_iter = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));

  ula_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (it_load),
    .step   (it_step),
    .mode   ((op_q == OP_DIV) ? MODE_DIV : MODE_MUL),
    .opa    (a_q),
    .opb    (b_q),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = EXEC;
      EXEC:    state_d = is_iter ? ITER : FIN;
      ITER:    if (cnt_q == '0) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cin_d    = cin_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    neg_d    = neg_q;
    err_d    = err_q;
    it_load  = 1'b0;
    it_step  = 1'b0;
    sum      = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};
    case (state_q)
      IDLE: if (start) begin
        a_d   = a;
        b_d   = b;
        op_d  = op;
        cin_d = cin;
      end
      EXEC: if (is_iter) begin
        it_load = 1'b1;
        cnt_d   = CNT_W'(WIDTH - 1);
      end else begin
        carry_d = 1'b0;
        neg_d   = 1'b0;
        err_d   = 1'b0;
        case (op_q)
          OP_ADD: begin
            result_d = RES_W'(sum);
            carry_d  = sum[WIDTH];
          end
          OP_SUB: begin
            result_d = RES_W'(diff[WIDTH-1:0]);
            neg_d    = diff[WIDTH];
          end
          OP_AND:  result_d = RES_W'(a_q & b_q);
          OP_OR:   result_d = RES_W'(a_q | b_q);
          OP_XOR:  result_d = RES_W'(a_q ^ b_q);
          default: begin
            result_d = '0;
            err_d    = 1'b1;
          end
        endcase
        zero_d = (result_d == '0);
      end
      ITER: begin
        it_step = 1'b1;
        if (cnt_q == '0) begin
          result_d = {acc_hi, acc_lo};
          zero_d   = (result_d == '0);
          carry_d  = 1'b0;
          neg_d    = 1'b0;
          err_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
    done_d = (state_d == FIN);
    busy_d = (state_d == EXEC) || (state_d == ITER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cin_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cin_q    <= cin_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_neg   = neg_q;
  assign flag_error = err_q;

endmodule

// File: tb/tb_ula_seq_param.sv
// Bench for ula_seq_param (WIDTH=8): cycle model of handshake/result plus directed literal checks.
module tb_ula_seq_param;
  import ula_pkg::*;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [2:0]  op;
  logic [W-1:0] a, b;
  logic        busy, done, fz, fc, fn, fe;
  logic [2*W-1:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = 0;

  // model state: mk counts cycles since accept (0 = idle), p_* is the pending answer
  int          mk = 0, p_lat = 0;
  logic [15:0] p_res = '0, m_res = '0;
  logic [3:0]  p_fl = '0, m_fl = '0;
  logic        m_busy = 1'b0, m_done = 1'b0;

  ula_seq_param #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result),
    .flag_zero(fz), .flag_carry(fc), .flag_neg(fn), .flag_error(fe)
  );

  always #5 clk = ~clk;

  function automatic void calc(input logic [2:0] o, input int x, input int y, input int c,
                               output logic [15:0] r, output logic [3:0] f, output int lat);
    int v;
    logic e, cy, ng;
    e = 1'b0; cy = 1'b0; ng = 1'b0; lat = 2; v = 0;
    case (o)
      3'd0: begin v = x + y + c; cy = (v > 255); end
      3'd1: begin v = (x - y) & 255; ng = (x < y); end
      3'd2: v = x & y;
      3'd3: v = x | y;
      3'd5: v = x ^ y;
      3'd4: begin v = x * y; lat = W + 2; end
      3'd6: if (y == 0) e = 1'b1;
            else begin v = (x % y) * 256 + x / y; lat = W + 2; end
      default: e = 1'b1;
    endcase
    r = v[15:0];
    f = {(v == 0), cy, ng, e};
  endfunction

  // advance the model across the coming edge using the inputs now applied
  task automatic model_step();
    if (rst) begin
      mk = 0; m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_fl = '0;
    end else if (mk == 0) begin
      m_done = 1'b0;
      if (start) begin
        calc(op, int'(a), int'(b), int'(cin), p_res, p_fl, p_lat);
        mk = 1;
      end
    end else if (mk == p_lat) begin
      mk = 0; m_done = 1'b0;
    end else begin
      mk++;
      if (mk == p_lat) begin
        m_done = 1'b1; m_res = p_res; m_fl = p_fl;
      end
    end
    m_busy = (mk >= 1) && (mk < p_lat);
  endtask

  task automatic tick();
    @(negedge clk);
    checks++;
    if ({busy, done} !== {m_busy, m_done}) begin
      errors++;
      $display("FAIL handshake cyc=%0d busy,done=%b%b want %b%b", cyc, busy, done, m_busy, m_done);
    end
    checks++;
    if ({result, fz, fc, fn, fe} !== {m_res, m_fl}) begin
      errors++;
      $display("FAIL outputs cyc=%0d result=%h zcne=%b want %h %b", cyc, result, {fz, fc, fn, fe}, m_res, m_fl);
    end
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic c, input logic [15:0] er, input logic [3:0] ef, input int el,
                        input bit noise);
    int n;
    tick();
    op = o; a = x; b = y; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      if (noise) begin
        start = (n == 4); op = OP_ADD; a = ~x; b = 8'h01;
      end
      tick();
      n++;
    end
    start = 1'b0;
    checks++;
    if (n != el) begin
      errors++; $display("FAIL %s latency got %0d want %0d", nm, n, el);
    end
    checks++;
    if (result !== er) begin
      errors++; $display("FAIL %s result got %h want %h", nm, result, er);
    end
    checks++;
    if ({fz, fc, fn, fe} !== ef) begin
      errors++; $display("FAIL %s flags zcne got %b want %b", nm, {fz, fc, fn, fe}, ef);
    end
    last_done = cyc;
  endtask

  initial begin
    int t0, nd;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, result, fz, fc, fn, fe} !== '0) begin
      errors++; $display("FAIL reset_state got %b want 0", {busy, done, result, fz, fc, fn, fe});
    end

    //      name         op      a      b      cin   result    zcne     lat noise
    run_op("add_carry", OP_ADD, 8'd200, 8'd100, 1'b1, 16'h012D, 4'b0100, 2, 1'b0);
    run_op("add_edge",  OP_ADD, 8'd255, 8'd0,   1'b1, 16'h0100, 4'b0100, 2, 1'b0);
    run_op("sub_neg",   OP_SUB, 8'd5,   8'd9,   1'b1, 16'h00FC, 4'b0010, 2, 1'b0);
    run_op("sub_zero",  OP_SUB, 8'd9,   8'd9,   1'b0, 16'h0000, 4'b1000, 2, 1'b0);
    run_op("or",        OP_OR,  8'h0F,  8'h30,  1'b0, 16'h003F, 4'b0000, 2, 1'b0);
    run_op("mul_max",   OP_MUL, 8'd255, 8'd255, 1'b0, 16'hFE01, 4'b0000, 10, 1'b1);
    run_op("mul_zero",  OP_MUL, 8'd0,   8'd77,  1'b1, 16'h0000, 4'b1000, 10, 1'b0);
    run_op("div",       OP_DIV, 8'd200, 8'd7,   1'b0, 16'h041C, 4'b0000, 10, 1'b0);
    run_op("div_by1",   OP_DIV, 8'd255, 8'd1,   1'b0, 16'h00FF, 4'b0000, 10, 1'b0);
    run_op("div_by0",   OP_DIV, 8'd13,  8'd0,   1'b0, 16'h0000, 4'b1001, 2, 1'b0);
    run_op("reserved",  OP_RSV, 8'd3,   8'd4,   1'b1, 16'h0000, 4'b1001, 2, 1'b0);

    // reset in the middle of a multiply: no done, everything cleared
    tick();
    op = OP_MUL; a = 8'd255; b = 8'd255; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, result, fz, fc, fn, fe} !== '0) begin
      errors++; $display("FAIL midop_reset got %b want 0", {busy, done, result, fz, fc, fn, fe});
    end
    nd = 0;
    repeat (14) begin
      tick();
      if (done) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++; $display("FAIL aborted_done pulses got %0d want 0", nd);
    end
    run_op("add_after_rst", OP_ADD, 8'd1, 8'd1, 1'b0, 16'h0002, 4'b0000, 2, 1'b0);

    // back-to-back: second start in the cycle right after the first done
    run_op("xor", OP_XOR, 8'hF0, 8'h3C, 1'b0, 16'h00CC, 4'b0000, 2, 1'b0);
    t0 = last_done;
    run_op("and", OP_AND, 8'hF0, 8'h3C, 1'b0, 16'h0030, 4'b0000, 2, 1'b0);
    checks++;
    if (last_done - t0 != 3) begin
      errors++; $display("FAIL b2b_spacing got %0d want 3", last_done - t0);
    end

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
